zx_mem_pager: RTL



---
 rtl/zx_mem_pager_if.sv | 36 +++
 rtl/zx_mem_pager.sv | 131 +++++++++++++
 2 files changed

// File: rtl/zx_mem_pager_if.sv
// rtl/zx_mem_pager_if.sv - CPU/loader bus and mapping outputs of the pager; rom_page widens under PLUS3_PAGING_EN
interface zx_mem_pager_if #(
    parameter int RAM_BANKS = 8
);
    localparam int BANK_W = $clog2(RAM_BANKS);
`ifdef PLUS3_PAGING_EN
    localparam int RW = 2;
`else
    localparam int RW = 1;
`endif

    logic [15:0]         addr;
    logic [7:0]          din;
    logic                iorq_n;
    logic                wr_n;
    logic                m1_n;
    logic                cfg_we;
    logic                cfg_sel;
    logic [7:0]          cfg_din;
    logic                is_rom;
    logic [RW-1:0]       rom_page;
    logic [BANK_W+13:0]  phys_addr;
    logic [BANK_W-1:0]   vid_bank;
    logic [7:0]          page_reg;
    logic                locked;

    modport master (
        output addr, din, iorq_n, wr_n, m1_n, cfg_we, cfg_sel, cfg_din,
        input  is_rom, rom_page, phys_addr, vid_bank, page_reg, locked
    );

    modport slave (
        input  addr, din, iorq_n, wr_n, m1_n, cfg_we, cfg_sel, cfg_din,
        output is_rom, rom_page, phys_addr, vid_bank, page_reg, locked
    );
endinterface

// File: rtl/zx_mem_pager.sv
// rtl/zx_mem_pager.sv - 128K-style banked memory pager with lockable 7FFD port; +3 1FFD paging under PLUS3_PAGING_EN
module zx_mem_pager #(
    parameter int RAM_BANKS = 8,
    parameter bit MODE48    = 1'b0
) (
    input logic           clk,
    input logic           reset_n,
    zx_mem_pager_if.slave bus
);
    localparam int BANK_W = $clog2(RAM_BANKS);
`ifdef PLUS3_PAGING_EN
    localparam int RW = 2;
`else
    localparam int RW = 1;
`endif

    logic [7:0]        page_reg_q, page_reg_d;
    logic              prev_strobe_q, prev_strobe_d;
`ifdef PLUS3_PAGING_EN
    logic [7:0]        plus3_reg_q, plus3_reg_d;
    logic              special_mode;
`endif
    logic              io_write;
    logic              dec_7ffd;
    logic              dec_1ffd;
    logic              wr_strobe;
    logic              cpu_capture;
    logic              locked;
    logic [BANK_W-1:0] c000_bank;
    logic [BANK_W-1:0] bank_sel;
    logic [BANK_W-1:0] vid_bank;
    logic [RW-1:0]     rom_page;
    logic              is_rom;

    // The lock lives in the 7FFD image itself, so a loader restore of bit5 sets or clears it
    assign locked = page_reg_q[5];

    // Port decode and rising-edge detection of the write strobe (one capture per I/O cycle)
    always_comb begin
        io_write = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;
        dec_7ffd = ~MODE48 & ~bus.addr[15] & ~bus.addr[1];
`ifdef PLUS3_PAGING_EN
        dec_1ffd = ~MODE48 & (bus.addr[15:12] == 4'b0001) & ~bus.addr[1];
`else
        dec_1ffd = 1'b0;
`endif
        wr_strobe   = io_write & (dec_7ffd | dec_1ffd);
        cpu_capture = wr_strobe & ~prev_strobe_q & ~locked;
    end

    // Next paging state: loader writes bypass the lock and override a coincident CPU write
    always_comb begin
        prev_strobe_d = wr_strobe;
        page_reg_d    = page_reg_q;
`ifdef PLUS3_PAGING_EN
        plus3_reg_d   = plus3_reg_q;
`endif
        if (bus.cfg_we) begin
            if (!bus.cfg_sel) page_reg_d = bus.cfg_din;
`ifdef PLUS3_PAGING_EN
            else plus3_reg_d = bus.cfg_din;
`endif
        end else if (cpu_capture) begin
            if (dec_7ffd) page_reg_d = bus.din;
`ifdef PLUS3_PAGING_EN
            if (dec_1ffd) plus3_reg_d = bus.din;
`endif
        end
    end

    // Paging registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            page_reg_q    <= 8'h00;
            prev_strobe_q <= 1'b0;
`ifdef PLUS3_PAGING_EN
            plus3_reg_q   <= 8'h00;
`endif
        end else begin
            page_reg_q    <= page_reg_d;
            prev_strobe_q <= prev_strobe_d;
`ifdef PLUS3_PAGING_EN
            plus3_reg_q   <= plus3_reg_d;
`endif
        end
    end

    // Combinational address translation; in 48K mode the paging image is ignored entirely
    always_comb begin
        c000_bank = MODE48 ? '0 : BANK_W'({page_reg_q[7:6], page_reg_q[2:0]});
        vid_bank  = (!MODE48 && page_reg_q[3]) ? BANK_W'(7) : BANK_W'(5);
        rom_page  = '0;
        if (!MODE48) begin
`ifdef PLUS3_PAGING_EN
            rom_page = {plus3_reg_q[2], page_reg_q[4]};
`else
            rom_page = page_reg_q[4];
`endif
        end
        is_rom   = 1'b0;
        bank_sel = '0;
        case (bus.addr[15:14])
            2'b00:   is_rom   = 1'b1;
            2'b01:   bank_sel = BANK_W'(5);
            2'b10:   bank_sel = BANK_W'(2);
            default: bank_sel = c000_bank;
        endcase
`ifdef PLUS3_PAGING_EN
        special_mode = ~MODE48 & plus3_reg_q[0];
        if (special_mode) begin
            is_rom = 1'b0;
            case (plus3_reg_q[2:1])
                2'b00:   bank_sel = BANK_W'(bus.addr[15:14]);
                2'b01:   bank_sel = BANK_W'({1'b1, bus.addr[15:14]});
                2'b10:   bank_sel = (bus.addr[15:14] == 2'b11) ? BANK_W'(3)
                                    : BANK_W'({1'b1, bus.addr[15:14]});
                default: bank_sel = (bus.addr[15:14] == 2'b11) ? BANK_W'(3)
                                    : (bus.addr[15:14] == 2'b01) ? BANK_W'(7)
                                    : BANK_W'({1'b1, bus.addr[15:14]});
            endcase
        end
`endif
    end

    assign bus.is_rom    = is_rom;
    assign bus.rom_page  = rom_page;
    assign bus.phys_addr = is_rom ? {BANK_W'(rom_page), bus.addr[13:0]} : {bank_sel, bus.addr[13:0]};
    assign bus.vid_bank  = vid_bank;
    assign bus.page_reg  = page_reg_q;
    assign bus.locked    = locked;
endmodule
